// File: rtl/accel_pkg.sv
// Shared accelerator definitions: output buffer sizing defaults, row type,
// and the output-buffer tile-state encoding.
package accel_pkg;

    localparam int unsigned OUTBUF_DEPTH  = 8;
    localparam int unsigned ROWS_PER_TILE = 8;
    localparam int unsigned ROW_W         = 64;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2
    } outbuf_state_e;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO control for the output buffer: pointers, occupancy, full/empty decode
// and sticky overflow/underflow flags.
// Optional feature macro: OUTPUT_BUFFER_OVERWRITE_EN (push while full
// overwrites the oldest entry instead of being dropped).
// Ports:
//   clk, n_rst        clock, async active-low reset
//   push_valid_i      row offered for write
//   pop_i             consumer takes the head
//   clear_i           synchronous flush of pointers, count and errors
//   wr_en_c           storage write strobe this cycle
//   rd_adv_c          read pointer advances this cycle (pop or overwrite)
//   wr_ptr_o/rd_ptr_o storage pointers
//   count_o           entries held; count_nxt_c is its next value
//   full_c/empty_c    occupancy decode
//   overflow_o        sticky, push hit full
//   underflow_o       sticky, pop hit empty
module fifo_ctrl #(
    parameter int unsigned DEPTH = accel_pkg::OUTBUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push_valid_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic                       wr_en_c,
    output logic                       rd_adv_c,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [$clog2(DEPTH+1)-1:0] count_nxt_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             pop_ok, push_ok, ovw;

    // Next-state for pointers, count and sticky errors.
    always_comb begin
        full_c   = (count_q == CNT_W'(DEPTH));
        empty_c  = (count_q == '0);
        pop_ok   = pop_i && !empty_c;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok  = push_valid_i && (!full_c || pop_ok);
`ifdef OUTPUT_BUFFER_OVERWRITE_EN
        ovw      = push_valid_i && full_c && !pop_i;
`else
        ovw      = 1'b0;
`endif
        wr_en_c  = push_ok || ovw;
        rd_adv_c = pop_ok || ovw;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv_c);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        ovf_d    = ovf_q || (push_valid_i && full_c && !pop_i);
        udf_d    = udf_q || (pop_i && empty_c);
        if (clear_i) begin
            wr_en_c  = 1'b0;
            rd_adv_c = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign count_o     = count_q;
    assign count_nxt_c = count_d;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: rtl/output_buffer.sv
// Output buffer between the activation stage and the AHB subordinate:
// a show-ahead FIFO of activated rows plus tile-completion tracking.
// Optional feature macro: OUTPUT_BUFFER_OVERWRITE_EN (handled in fifo_ctrl).
// Ports:
//   clk, n_rst              clock, async active-low reset
//   push_valid, push_data   activated row in
//   pop                     head consumed by the subordinate
//   clear                   synchronous flush (wins over push/pop)
//   rd_data                 head entry, 0 while empty
//   count, empty, full      occupancy
//   tile_ready              at least one complete tile buffered
//   overflow_err            sticky, push hit full
//   underflow_err           sticky, pop hit empty
module output_buffer #(
    parameter int unsigned DEPTH         = accel_pkg::OUTBUF_DEPTH,
    parameter int unsigned ROWS_PER_TILE = accel_pkg::ROWS_PER_TILE
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       push_valid,
    input  logic [63:0]                push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [63:0]                rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       tile_ready,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ROW_W = (ROWS_PER_TILE > 1) ? $clog2(ROWS_PER_TILE) : 1;

    accel_pkg::row_t          mem_q [DEPTH];
    logic                     wr_en, rd_adv;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         count_nxt;

    logic [ROW_W-1:0]         row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]         pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0]         tiles_q, tiles_d;
    logic                     row_wrap, pop_wrap;
    accel_pkg::outbuf_state_e state_q, state_d;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_fifo_ctrl (
        .clk          (clk),
        .n_rst        (n_rst),
        .push_valid_i (push_valid),
        .pop_i        (pop),
        .clear_i      (clear),
        .wr_en_c      (wr_en),
        .rd_adv_c     (rd_adv),
        .wr_ptr_o     (wr_ptr),
        .rd_ptr_o     (rd_ptr),
        .count_o      (count),
        .count_nxt_c  (count_nxt),
        .full_c       (full),
        .empty_c      (empty),
        .overflow_o   (overflow_err),
        .underflow_o  (underflow_err)
    );

    // Row storage; contents are don't-care after reset or clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= push_data;
        end
    end

    assign rd_data = empty ? 64'd0 : mem_q[rd_ptr];

    // Tile counters: rows written and rows removed, each wrapping per tile.
    always_comb begin
        row_wrap  = wr_en && (row_cnt_q == ROW_W'(ROWS_PER_TILE - 1));
        pop_wrap  = rd_adv && (pop_cnt_q == ROW_W'(ROWS_PER_TILE - 1));
        row_cnt_d = row_cnt_q;
        pop_cnt_d = pop_cnt_q;
        if (wr_en) begin
            row_cnt_d = row_wrap ? '0 : row_cnt_q + ROW_W'(1);
        end
        if (rd_adv) begin
            pop_cnt_d = pop_wrap ? '0 : pop_cnt_q + ROW_W'(1);
        end
        tiles_d = tiles_q + CNT_W'(row_wrap) - CNT_W'(pop_wrap);
        if (clear) begin
            row_cnt_d = '0;
            pop_cnt_d = '0;
            tiles_d   = '0;
        end
    end

    // Tile FSM: state tracks the next counter values so tile_ready is registered.
    always_comb begin
        state_d = state_q;
        if (tiles_d != '0) begin
            state_d = accel_pkg::READY;
        end else if (count_nxt != '0) begin
            state_d = accel_pkg::FILLING;
        end else begin
            state_d = accel_pkg::EMPTY;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_cnt_q <= '0;
            pop_cnt_q <= '0;
            tiles_q   <= '0;
            state_q   <= accel_pkg::EMPTY;
        end else begin
            row_cnt_q <= row_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            tiles_q   <= tiles_d;
            state_q   <= state_d;
        end
    end

    assign tile_ready = (state_q == accel_pkg::READY);

endmodule

// File: tb/tb_output_buffer.sv
// Directed self-checking bench for output_buffer (DEPTH 8, 8 rows per tile).
module tb_output_buffer;

    logic        clk;
    logic        n_rst;
    logic        push_valid;
    logic [63:0] push_data;
    logic        pop;
    logic        clear;
    logic [63:0] rd_data;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        tile_ready;
    logic        overflow_err;
    logic        underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] ONES = 64'h1111_1111_1111_1111;
    localparam logic [63:0] DEAD = 64'hDEAD_DEAD_DEAD_DEAD;

    output_buffer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .push_valid    (push_valid),
        .push_data     (push_data),
        .pop           (pop),
        .clear         (clear),
        .rd_data       (rd_data),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .tile_ready    (tile_ready),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic pv, input logic [63:0] pd, input logic pp, input logic cl);
        push_valid = pv;
        push_data  = pd;
        pop        = pp;
        clear      = cl;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        push_data  = '0;
        pop        = 1'b0;
        clear      = 1'b0;
    endtask

    logic [63:0] q[$];
    logic [63:0] exp_rows[8];
    logic [63:0] v;

    initial begin
        n_rst = 1'b0;
        push_valid = 1'b0;
        push_data = '0;
        pop = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Reset / idle state
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_tile_ready", 64'(tile_ready), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        check("rst_udf", 64'(underflow_err), 64'd0);

        // Fill one tile
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, ONES * 64'(i), 1'b0, 1'b0);
            if (i == 1) begin
                check("push1_count", 64'(count), 64'd1);
                check("push1_head", rd_data, ONES);
            end
            if (i == 7) check("push7_tile_ready", 64'(tile_ready), 64'd0);
        end
        check("fill_tile_ready", 64'(tile_ready), 64'd1);
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd8);

        // Drain in order
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", rd_data, ONES * 64'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
            if (i == 7) check("drain7_tile_ready", 64'(tile_ready), 64'd1);
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_tile_ready", 64'(tile_ready), 64'd0);
        check("drain_rd_data", rd_data, 64'd0);
        check("drain_udf", 64'(underflow_err), 64'd0);

        // Push while full
        for (int i = 1; i <= 8; i++) cyc(1'b1, ONES * 64'(i), 1'b0, 1'b0);
        cyc(1'b1, DEAD, 1'b0, 1'b0);
        check("ovf_flag", 64'(overflow_err), 64'd1);
        check("ovf_count", 64'(count), 64'd8);
`ifdef OUTPUT_BUFFER_OVERWRITE_EN
        for (int i = 0; i < 7; i++) exp_rows[i] = ONES * 64'(i + 2);
        exp_rows[7] = DEAD;
`else
        for (int i = 0; i < 8; i++) exp_rows[i] = ONES * 64'(i + 1);
`endif
        check("ovf_head", rd_data, exp_rows[0]);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain", rd_data, exp_rows[i]);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("ovf_drain_empty", 64'(empty), 64'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", 64'(overflow_err), 64'd0);
        check("clr_tile_ready", 64'(tile_ready), 64'd0);

        // Pop while empty
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("udf_flag", 64'(underflow_err), 64'd1);
        check("udf_count", 64'(count), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("clr_udf", 64'(underflow_err), 64'd0);

        // Steady push+pop at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            v = 64'hA000_0000_0000_0000 + 64'(i);
            cyc(1'b1, v, 1'b0, 1'b0);
            q.push_back(v);
        end
        check("pp_pre_count", 64'(count), 64'd3);
        for (int i = 3; i < 23; i++) begin
            v = 64'hA000_0000_0000_0000 + 64'(i);
            check("pp_head", rd_data, q[0]);
            cyc(1'b1, v, 1'b1, 1'b0);
            void'(q.pop_front());
            q.push_back(v);
            check("pp_count", 64'(count), 64'd3);
        end
        check("pp_head_end", rd_data, q[0]);
        check("pp_ovf", 64'(overflow_err), 64'd0);
        check("pp_udf", 64'(underflow_err), 64'd0);

        // Async reset mid-cycle at count 5
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h5500 + 64'(i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_udf", 64'(underflow_err), 64'd0);
        cyc(1'b1, 64'h5505, 1'b0, 1'b0);
        cyc(1'b1, 64'h5506, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd5);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_empty", 64'(empty), 64'd1);
        check("arst_full", 64'(full), 64'd0);
        check("arst_rd_data", rd_data, 64'd0);
        check("arst_tile_ready", 64'(tile_ready), 64'd0);
        check("arst_ovf", 64'(overflow_err), 64'd0);
        check("arst_udf", 64'(underflow_err), 64'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("post_rst_empty", 64'(empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
